// File: rtl/zeroriscy_ex_issue_ctrl_pkg.sv
// Shared types and helpers for the ID-side EX issue controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package zeroriscy_ex_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        EX_OP_ALU  = 3'd0,
        EX_OP_MULT = 3'd1,
        EX_OP_DIV  = 3'd2,
        EX_OP_BNN  = 3'd3,
        EX_OP_LSU  = 3'd4
    } ex_op_class_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } ex_issue_state_e;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    // Classes 5-7 never exist; MULT/DIV and BNN depend on the unit being built.
    function automatic logic op_is_legal(input logic [2:0] op,
                                         input logic       rv32m,
                                         input logic       bnn_en);
        logic legal;
        case (op)
            3'd0:    legal = 1'b1;
            3'd1:    legal = rv32m;
            3'd2:    legal = rv32m;
            3'd3:    legal = bnn_en;
            3'd4:    legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Enable vector ordered {lsu, bnn, div, mult}; ALU and unknown classes map to zero.
    function automatic logic [3:0] op_enables(input ex_op_class_e op);
        logic [3:0] en;
        case (op)
            EX_OP_MULT: en = 4'b0001;
            EX_OP_DIV:  en = 4'b0010;
            EX_OP_BNN:  en = 4'b0100;
            EX_OP_LSU:  en = 4'b1000;
            default:    en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/zeroriscy_ex_issue_ctrl.sv
// Issues one decoded instruction to EX and holds its unit enable until EX reports ready.
// Latency: ALU/illegal retire combinationally in the issue cycle; multi-cycle ops retire on ex_ready_i.
// Backpressure: id_ready_o stays low while waiting on EX; a watchdog drops the op after MAX_WAIT_CYCLES.
module zeroriscy_ex_issue_ctrl
    import zeroriscy_ex_issue_ctrl_pkg::*;
#(
    parameter bit          RV32M           = 1'b1,
    parameter bit          BNN_EN          = 1'b1,
    parameter int unsigned MAX_WAIT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid_i,
    input  ex_op_class_e op_class_i,
    input  logic         rf_we_i,
    input  logic [4:0]   rf_waddr_i,
    input  logic         flush_i,
    output logic         id_ready_o,
    output logic         mult_en_o,
    output logic         div_en_o,
    output logic         bnn_en_o,
    output logic         lsu_en_o,
    input  logic         ex_ready_i,
    input  logic [31:0]  regfile_wdata_ex_i,
    output logic         regfile_we_o,
    output logic [4:0]   regfile_waddr_o,
    output logic [31:0]  regfile_wdata_o,
    output logic         illegal_op_o,
    output logic         timeout_o,
    output logic [31:0]  stall_cycles_o
);

    localparam int unsigned WCW = $clog2(MAX_WAIT_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT_CYCLES);

    ex_issue_state_e state_q, state_d;
    ex_op_class_e    op_q, op_d;
    logic            we_q, we_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;

    logic [3:0]      en;

    // Next-state and output decode for the issue FSM, watchdog and stall counter.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        we_d            = we_q;
        waddr_d         = waddr_q;
        wait_cnt_d      = wait_cnt_q;
        stall_cycles_d  = stall_cycles_q;
        en              = 4'b0000;
        id_ready_o      = 1'b0;
        regfile_we_o    = 1'b0;
        regfile_waddr_o = 5'd0;
        illegal_op_o    = 1'b0;
        timeout_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (instr_valid_i) begin
                    if (!op_is_legal(op_class_i, RV32M, BNN_EN)) begin
                        id_ready_o   = 1'b1;
                        illegal_op_o = 1'b1;
                    end else if (op_class_i == EX_OP_ALU) begin
                        id_ready_o      = 1'b1;
                        regfile_we_o    = rf_we_i;
                        regfile_waddr_o = rf_waddr_i;
                    end else begin
                        // Enable goes out in the issue cycle so single-cycle EX
                        // units can complete without ever entering WAIT.
                        en      = op_enables(op_class_i);
                        op_d    = op_class_i;
                        we_d    = rf_we_i;
                        waddr_d = rf_waddr_i;
                        if (ex_ready_i) begin
                            id_ready_o      = 1'b1;
                            regfile_we_o    = rf_we_i;
                            regfile_waddr_o = rf_waddr_i;
                        end else begin
                            state_d    = WAIT;
                            wait_cnt_d = WCW'(1);
                        end
                    end
                end
            end

            WAIT: begin
                if (stall_cycles_q != STALL_CNT_MAX) begin
                    stall_cycles_d = stall_cycles_q + 32'd1;
                end
                if (flush_i) begin
                    // Flush beats both completion and watchdog expiry.
                    state_d = FLUSH;
                end else begin
                    // Driven from latched state only, so EX sees a stable enable
                    // even if ID inputs wander while we wait.
                    en = op_enables(op_q);
                    if (ex_ready_i) begin
                        id_ready_o      = 1'b1;
                        regfile_we_o    = we_q;
                        regfile_waddr_o = waddr_q;
                        state_d         = IDLE;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        timeout_o  = 1'b1;
                        id_ready_o = 1'b1;
                        state_d    = FLUSH;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            FLUSH: begin
                // One dead cycle with enables low lets multdiv/bnn return to idle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {lsu_en_o, bnn_en_o, div_en_o, mult_en_o} = en;
    assign regfile_wdata_o = regfile_wdata_ex_i;
    assign stall_cycles_o  = stall_cycles_q;

    // State, latched instruction fields and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= EX_OP_ALU;
            we_q           <= 1'b0;
            waddr_q        <= 5'd0;
            wait_cnt_q     <= '0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_zeroriscy_ex_issue_ctrl.sv
// Scoreboard bench: the driver predicts each instruction's outcome and the monitor checks retires.
// Latency: n/a.
// Backpressure: n/a.
module tb_zeroriscy_ex_issue_ctrl;
    import zeroriscy_ex_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        instr_valid = 1'b0;
    logic [2:0]  op_in = 3'd0;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = 5'd0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic [31:0] wdata_in = 32'd0;

    logic        id_ready [3];
    logic        mult_en  [3];
    logic        div_en   [3];
    logic        bnn_en   [3];
    logic        lsu_en   [3];
    logic        rf_we_o  [3];
    logic [4:0]  waddr_o  [3];
    logic [31:0] wdata_o  [3];
    logic        illegal  [3];
    logic        timeout  [3];
    logic [31:0] stall    [3];

    zeroriscy_ex_issue_ctrl #(.RV32M(1'b1), .BNN_EN(1'b1), .MAX_WAIT_CYCLES(64)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .op_class_i(ex_op_class_e'(op_in)),
        .rf_we_i(rf_we), .rf_waddr_i(rf_waddr), .flush_i(flush), .id_ready_o(id_ready[0]),
        .mult_en_o(mult_en[0]), .div_en_o(div_en[0]), .bnn_en_o(bnn_en[0]), .lsu_en_o(lsu_en[0]),
        .ex_ready_i(ex_ready), .regfile_wdata_ex_i(wdata_in), .regfile_we_o(rf_we_o[0]),
        .regfile_waddr_o(waddr_o[0]), .regfile_wdata_o(wdata_o[0]), .illegal_op_o(illegal[0]),
        .timeout_o(timeout[0]), .stall_cycles_o(stall[0]));

    zeroriscy_ex_issue_ctrl #(.RV32M(1'b1), .BNN_EN(1'b1), .MAX_WAIT_CYCLES(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .op_class_i(ex_op_class_e'(op_in)),
        .rf_we_i(rf_we), .rf_waddr_i(rf_waddr), .flush_i(flush), .id_ready_o(id_ready[1]),
        .mult_en_o(mult_en[1]), .div_en_o(div_en[1]), .bnn_en_o(bnn_en[1]), .lsu_en_o(lsu_en[1]),
        .ex_ready_i(ex_ready), .regfile_wdata_ex_i(wdata_in), .regfile_we_o(rf_we_o[1]),
        .regfile_waddr_o(waddr_o[1]), .regfile_wdata_o(wdata_o[1]), .illegal_op_o(illegal[1]),
        .timeout_o(timeout[1]), .stall_cycles_o(stall[1]));

    zeroriscy_ex_issue_ctrl #(.RV32M(1'b0), .BNN_EN(1'b0), .MAX_WAIT_CYCLES(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .op_class_i(ex_op_class_e'(op_in)),
        .rf_we_i(rf_we), .rf_waddr_i(rf_waddr), .flush_i(flush), .id_ready_o(id_ready[2]),
        .mult_en_o(mult_en[2]), .div_en_o(div_en[2]), .bnn_en_o(bnn_en[2]), .lsu_en_o(lsu_en[2]),
        .ex_ready_i(ex_ready), .regfile_wdata_ex_i(wdata_in), .regfile_we_o(rf_we_o[2]),
        .regfile_waddr_o(waddr_o[2]), .regfile_wdata_o(wdata_o[2]), .illegal_op_o(illegal[2]),
        .timeout_o(timeout[2]), .stall_cycles_o(stall[2]));

    typedef struct {
        logic        illegal;
        logic        timeout;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] stall;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          sel = 0;
    bit          mon_on = 1'b0;
    logic [3:0]  exp_en = 4'b0;
    bit          exp_stall_vld = 1'b0;
    logic [31:0] exp_stall = 32'd0;
    longint      stall_total = 0;
    logic [3:0]  en_now;
    exp_t        e;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut=%0d actual=0x%0h required=0x%0h t=%0t", name, sel, act, req, $time);
        end
    endfunction

    function automatic longint sat(longint x);
        return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
    endfunction

    function automatic int cfg_max();
        return (sel == 0) ? 64 : (sel == 1) ? 8 : 16;
    endfunction

    function automatic bit cfg_legal(int op);
        bit m = (sel != 2);
        bit b = (sel != 2);
        if (op == 0 || op == 4) return 1'b1;
        if (op == 1 || op == 2) return m;
        if (op == 3) return b;
        return 1'b0;
    endfunction

    // Checks every cycle; pops one expected record per retire the DUT presents.
    always @(negedge clk) begin
        if (mon_on) begin
            en_now = {lsu_en[sel], bnn_en[sel], div_en[sel], mult_en[sel]};
            chk("enables", {28'd0, en_now}, {28'd0, exp_en});
            chk("we_without_ready", {31'd0, rf_we_o[sel] & ~id_ready[sel]}, 32'd0);
            if (id_ready[sel]) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready dut=%0d actual=1 required=0 t=%0t", sel, $time);
                end else begin
                    e = q.pop_front();
                    chk("illegal_op", {31'd0, illegal[sel]}, {31'd0, e.illegal});
                    chk("timeout", {31'd0, timeout[sel]}, {31'd0, e.timeout});
                    chk("regfile_we", {31'd0, rf_we_o[sel]}, {31'd0, e.we});
                    if (e.we) begin
                        chk("regfile_waddr", {27'd0, waddr_o[sel]}, {27'd0, e.waddr});
                        chk("regfile_wdata", wdata_o[sel], e.wdata);
                    end
                    chk("stall_at_retire", stall[sel], e.stall);
                end
            end else begin
                chk("illegal_no_ready", {31'd0, illegal[sel]}, 32'd0);
                chk("timeout_no_ready", {31'd0, timeout[sel]}, 32'd0);
            end
            if (exp_stall_vld) chk("stall_cycles", stall[sel], exp_stall);
        end
    end

    // Advance one cycle; anything still queued means a retire never appeared.
    task automatic step();
        @(posedge clk);
        #1;
        chk("missing_ready", q.size(), 32'd0);
        q.delete();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            instr_valid   = 1'b0;
            flush         = 1'b0;
            ex_ready      = 1'($urandom % 2);
            op_in         = 3'($urandom % 8);
            exp_en        = 4'b0;
            exp_stall_vld = 1'b1;
            exp_stall     = 32'(stall_total);
            step();
        end
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        instr_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, id_ready[sel]}, 32'd0);
        chk("rst_en", {28'd0, lsu_en[sel], bnn_en[sel], div_en[sel], mult_en[sel]}, 32'd0);
        chk("rst_we", {31'd0, rf_we_o[sel]}, 32'd0);
        chk("rst_waddr", {27'd0, waddr_o[sel]}, 32'd0);
        chk("rst_pulses", {30'd0, illegal[sel], timeout[sel]}, 32'd0);
        chk("rst_stall", stall[sel], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall_total = 0;
        q.delete();
        mon_on = 1'b1;
    endtask

    // Outcome kinds: 0 retire, 1 flushed, 2 timeout, 3 illegal.
    task automatic issue(int op, bit we, int waddr, int delay, int flush_at);
        int max_w = cfg_max();
        bit legal = cfg_legal(op);
        bit multi = legal && (op >= 1) && (op <= 4);
        int lim;
        int end_j;
        int kind;
        logic [3:0] onehot;
        exp_t r;
        onehot = multi ? 4'(1 << (op - 1)) : 4'b0;
        lim = (delay < max_w) ? delay : max_w;
        if (flush_at == 0) begin
            kind = 1; end_j = 0;
        end else if (!legal) begin
            kind = 3; end_j = 0;
        end else if (!multi) begin
            kind = 0; end_j = 0;
        end else if (flush_at > 0 && flush_at <= lim) begin
            kind = 1; end_j = flush_at;
        end else if (delay <= max_w) begin
            kind = 0; end_j = delay;
        end else begin
            kind = 2; end_j = max_w;
        end
        for (int j = 0; j <= end_j; j++) begin
            instr_valid   = 1'b1;
            op_in         = 3'(op);
            rf_we         = we;
            rf_waddr      = 5'(waddr);
            wdata_in      = $urandom;
            ex_ready      = (j == delay);
            flush         = (j == flush_at);
            exp_en        = (kind == 1 && j == end_j) ? 4'b0 : onehot;
            exp_stall_vld = (j == 0);
            exp_stall     = 32'(stall_total);
            if (j == end_j && kind != 1) begin
                r.illegal = (kind == 3);
                r.timeout = (kind == 2);
                r.we      = (kind == 0) ? we : 1'b0;
                r.waddr   = 5'(waddr);
                r.wdata   = wdata_in;
                r.stall   = 32'(sat(stall_total + ((j > 0) ? j - 1 : 0)));
                q.push_back(r);
            end
            step();
        end
        stall_total = sat(stall_total + end_j);
        if (kind == 1 || kind == 2) begin
            // FLUSH cycle: inputs deliberately busy, DUT must stay quiet.
            instr_valid   = 1'b1;
            op_in         = 3'($urandom_range(1, 4));
            ex_ready      = 1'b1;
            flush         = 1'b0;
            exp_en        = 4'b0;
            exp_stall_vld = 1'b1;
            exp_stall     = 32'(stall_total);
            step();
        end
        instr_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
    endtask

    task automatic random_run(int n);
        int d, f, mx;
        mx = cfg_max();
        for (int i = 0; i < n; i++) begin
            d = ($urandom % 3 == 0) ? 0 : $urandom_range(1, mx + 4);
            f = ($urandom % 6 == 0) ? $urandom_range(0, (d < mx) ? d : mx) : -1;
            issue($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 31), d, f);
            idle($urandom % 3);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Phase 0: full-featured unit, long watchdog.
        sel = 0;
        do_reset();
        idle(2);
        issue(0, 1'b1, 5, 0, -1);          // ALU, same-cycle write to x5
        idle(1);
        issue(2, 1'b1, 12, 34, -1);        // DIV, 35 cycles with div_en, stall 34
        idle(2);
        issue(3, 1'b1, 7, 3, 3);           // BNN, flush wins over ready in WAIT cycle 3
        idle(1);
        issue(4, 1'b1, 9, 0, -1);          // LSU completes in issue cycle
        issue(1, 1'b0, 3, 2, -1);          // back-to-back MULT
        issue(0, 1'b1, 1, 0, 0);           // flush in IDLE
        idle(1);
        issue(6, 1'b1, 2, 0, -1);          // class 6 illegal
        idle(1);
        // Saturation: preload the counter just below the top.
        instr_valid = 1'b0;
        exp_en = 4'b0;
        exp_stall_vld = 1'b0;
        force u_dut0.stall_cycles_d = 32'hFFFF_FFFC;
        step();
        release u_dut0.stall_cycles_d;
        stall_total = 64'hFFFF_FFFC;
        issue(4, 1'b1, 20, 10, -1);
        idle(3);
        random_run(120);
        idle(2);
        // Asynchronous reset while a DIV is waiting.
        for (int j = 0; j < 5; j++) begin
            instr_valid = 1'b1;
            op_in = 3'd2;
            rf_we = 1'b1;
            rf_waddr = 5'd11;
            ex_ready = 1'b0;
            flush = 1'b0;
            exp_en = 4'b0010;
            exp_stall_vld = (j == 0);
            exp_stall = 32'(stall_total);
            step();
        end
        #2;
        do_reset();
        idle(2);

        // Phase 1: short watchdog.
        sel = 1;
        do_reset();
        idle(1);
        issue(1, 1'b1, 4, 1000, -1);       // MULT never completes: timeout at wait_cnt 8
        idle(1);
        issue(1, 1'b1, 4, 1000, 8);        // flush coincides with timeout
        idle(1);
        issue(2, 1'b1, 6, 8, -1);          // ready exactly at the limit still retires
        random_run(40);
        idle(2);

        // Phase 2: no M extension, no BNN.
        sel = 2;
        do_reset();
        idle(1);
        issue(1, 1'b1, 8, 0, -1);          // MULT illegal
        issue(2, 1'b1, 8, 3, -1);          // DIV illegal
        issue(3, 1'b1, 8, 0, -1);          // BNN illegal
        issue(4, 1'b1, 8, 5, -1);
        random_run(40);
        idle(2);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
